posit_add_arbiter_es3: RTL
==========================

# posit_add_arbiter_es3

Round-robin scheduler that shares one 4-stage ES=3 posit adder (32-bit, start/done, no stall) among NREQ requesters. It grants at most one operand pair per cycle and tracks the requester ID of every in-flight operation in a tag pipeline matched to the adder latency. Results go into an output FIFO with valid/ready. Issue is credit-gated, so a result is never lost when the consumer stalls.

## Interface
- NREQ, 4: number of requesters, 2..16.
- LATENCY, 4: cycles from add_start high to the matching add_done high; must equal the adder's pipeline depth.
- FIFO_DEPTH, 8: output FIFO entries, power of two, at least 2.
- IDW, $clog2(NREQ): requester ID width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_in1, req_in2  in  NREQ*32  packed posit operands; requester i occupies bits [32i+31:32i].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- add_start, add_in1[32], add_in2[32]  out  drive the adder.
- add_result[32], add_inf, add_zero, add_done  in  adder outputs.
- rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  IDW; rsp_result  out  32; rsp_inf, rsp_zero  out  1: response channel (FIFO head).
- busy  out  1  any operation in flight or FIFO not empty.
- err_desync  out  1  sticky flag: an expected add_done was missing.

## Operation
- **Arbitration:** each cycle, search req_valid starting at rr_ptr and pick the first set bit. Grant only when can_issue is true.
  - can_issue = (fifo_count + inflight_count) < FIFO_DEPTH, using registered values only. A same-cycle rsp pop does not free a credit until the next cycle.
  - req_ready is combinational from req_valid, rr_ptr and the registered counters. It never depends on rsp_ready.
  - On a grant to requester g: rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
- **Issue:** add_start = grant. add_in1/add_in2 carry the granted requester's operands in the same cycle. When no grant occurs, add_in1/add_in2 are 0.
- **Tag pipeline:** a LATENCY-deep shift register of {valid, id}.
  - Stage 0 is loaded with {grant, g}.
  - inflight_count increments on issue, decrements when a tag leaves the last stage, and is unchanged when both happen in the same cycle.
- **Completion:** the last tag stage is aligned to the cycle in which the adder presents add_done.
  - Tag valid and add_done high: push {id, add_result, add_inf, add_zero} into the FIFO.
  - Tag valid and add_done low: set err_desync and drop the entry.
  - Tag invalid and add_done high: discard the result silently. This covers results left in the adder from before a reset.
- **FIFO:** circular buffer with wrapping read/write pointers and a count 0..FIFO_DEPTH.
  - rsp_valid = (count != 0); the rsp_* data fields show the head entry.
  - A pop occurs when rsp_valid and rsp_ready are both high. Push and pop can happen in the same cycle.
  - Credit gating guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- **Reset (rst_n low, asynchronous):**
  - rr_ptr=0, all tag stages invalid, inflight_count=0, FIFO empty, err_desync=0.
  - Outputs: add_start=0, req_ready=0, rsp_valid=0, busy=0.
  - Operations in flight at reset are abandoned. Their late add_done pulses are discarded under the tag-invalid rule.
- **Widths:** the counters are $clog2(FIFO_DEPTH)+1 bits wide. Their sum is compared at that width plus one bit, so it cannot overflow.

## Timing
- **Issue:** an operand transfer in cycle t produces add_start high in cycle t.
- **Response latency:**
  - add_done is high in cycle t+LATENCY.
  - The FIFO entry is written at the end of cycle t+LATENCY.
  - rsp_valid rises in cycle t+LATENCY+1 when the FIFO was empty.
  - Minimum request-to-response latency is LATENCY+1 cycles.
- **Throughput:** one operation per cycle while credits remain. The credit check uses registered state, so back-to-back issue is sustained only while FIFO occupancy plus in-flight count stays below FIFO_DEPTH.
- **Ordering:** responses leave in issue order, which is global FIFO order.
- **Requester rules:** a requester must hold req_valid and its operands stable until granted. Dropping req_valid before the grant is permitted but withdraws the request.

## Test plan
- **Single request:** reset, then req_valid=0001, in1=0x40000000, in2=0x40000000.
  - req_ready=0001 in the same cycle.
  - Exactly 5 cycles later: rsp_valid=1, rsp_id=0, rsp_result equals the adder output for that operand pair.
- **Fairness:** all four requesters held valid, rsp_ready=1.
  - Grant sequence is 0,1,2,3,0,1…
  - One grant per cycle; rsp_id follows the same sequence offset by 5 cycles.
- **Backpressure:** rsp_ready=0, all requesters valid, FIFO_DEPTH=8.
  - Exactly 8 grants, then req_ready=0 while the FIFO is full.
  - One pop (rsp_ready=1 for one cycle) allows exactly one further grant, starting the cycle after the pop.
- **Simultaneous push and pop:** with FIFO count=3, a push and a pop in the same cycle leave count=3 with data in order.
- **Reset mid-flight:** issue 3 operations, assert rst_n=0 for 1 cycle before they complete.
  - No rsp_valid afterwards.
  - The stale add_done pulses are ignored and err_desync stays 0.
- **Missing done:** force add_done=0 when a tag is due.
  - err_desync=1 on the next cycle and stays set until reset.
  - No FIFO push; inflight_count still decrements.

Source files
------------

// File: rtl/posit_add_arbiter_es3.sv
// Round-robin front end that shares one pipelined ES=3 posit adder among NREQ requesters.
// Tags follow each operation through the adder; results queue in a credit-gated output FIFO.
module posit_add_arbiter_es3 #(
   parameter int NREQ       = 4,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int IDW        = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*32-1:0]   req_in1,
   input  logic [NREQ*32-1:0]   req_in2,
   output logic [NREQ-1:0]      req_ready,
   output logic                 add_start,
   output logic [31:0]          add_in1,
   output logic [31:0]          add_in2,
   input  logic [31:0]          add_result,
   input  logic                 add_inf,
   input  logic                 add_zero,
   input  logic                 add_done,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_result,
   output logic                 rsp_inf,
   output logic                 rsp_zero,
   output logic                 busy,
   output logic                 err_desync
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    res;
      logic           inf;
      logic           zero;
   } rsp_t;

   logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
   logic [LATENCY-1:0]          tag_vld_q;
   logic [LATENCY-1:0][IDW-1:0] tag_id_q;
   logic [CW-1:0]               infl_q, infl_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [AW-1:0]               wptr_q, rptr_q;
   logic                        err_q;
   rsp_t                        mem_q [FIFO_DEPTH];

   logic [IDW:0]   scan;
   logic           found, can_issue, grant;
   logic [IDW-1:0] gidx;
   logic           tag_last, push, miss, pop;
   rsp_t           head;

   // Rotating priority search starting at rr_ptr; scan stays below NREQ.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      scan  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
         if (!found && req_valid[scan[IDW-1:0]]) begin
            found = 1'b1;
            gidx  = scan[IDW-1:0];
         end
      end
   end

   // Credits come from registered state only, so a same-cycle pop frees nothing yet.
   assign can_issue = ({1'b0, cnt_q} + {1'b0, infl_q}) < (CW+1)'(FIFO_DEPTH);
   assign grant     = found & can_issue & rst_n;
   assign add_start = grant;

   always_comb begin
      req_ready = '0;
      add_in1   = '0;
      add_in2   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant && gidx == IDW'(i)) begin
            req_ready[i] = 1'b1;
            add_in1      = req_in1[i*32 +: 32];
            add_in2      = req_in2[i*32 +: 32];
         end
      end
   end

   assign tag_last = tag_vld_q[LATENCY-1];
   assign push     = tag_last & add_done;
   assign miss     = tag_last & ~add_done;
   assign pop      = rsp_valid & rsp_ready;

   assign rr_ptr_d = !grant ? rr_ptr_q :
                     (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
   assign infl_d   = infl_q + CW'(grant) - CW'(tag_last);
   assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
         infl_q    <= '0;
         cnt_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         tag_vld_q[0] <= grant;
         tag_id_q[0]  <= gidx;
         for (int i = 1; i < LATENCY; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
         infl_q <= infl_d;
         cnt_q  <= cnt_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (miss) err_q  <= 1'b1;
      end
   end

   // Payload storage needs no reset; count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= '{id: tag_id_q[LATENCY-1], res: add_result,
                                   inf: add_inf, zero: add_zero};
   end

   assign head       = mem_q[rptr_q];
   assign rsp_valid  = (cnt_q != '0);
   assign rsp_id     = head.id;
   assign rsp_result = head.res;
   assign rsp_inf    = head.inf;
   assign rsp_zero   = head.zero;
   assign busy       = (infl_q != '0) || (cnt_q != '0);
   assign err_desync = err_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && cnt_q == CW'(FIFO_DEPTH)));

endmodule
